frame_timing_gen: RTL and testbench
===================================

FRAME_TIMING_GEN -- requirements
Module: frame_timing_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 640: active pixels (dval beats) per line.
REQ-002 SHALL have parameter HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameter FV_TO_LV, default 4: cycles with fval=1 and lval=0 before the first line.
REQ-004 SHALL have parameter H_BLANK, default 16: cycles with lval=0 between lines, fval held high.
REQ-005 SHALL have parameter LV_TO_FV, default 4: cycles with fval=1 and lval=0 after the last line.
REQ-006 SHALL have parameter F_BLANK, default 32: cycles with fval=0 between frames.
REQ-007 SHALL have parameter TILE_LOG2, default 5: log2 of the checker tile edge in pixels.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-010 SHALL have port en, input, 1 bit: frame generation enable.
REQ-011 SHALL have port sel, input, 3 bits: pattern select.
REQ-012 SHALL have port hold, input, 1 bit: pixel stall request.
REQ-013 SHALL have port fval, output, 1 bit: frame valid.
REQ-014 SHALL have port lval, output, 1 bit: line valid.
REQ-015 SHALL have port dval, output, 1 bit: data valid.
REQ-016 SHALL have port pix_data, output, 8 bits: pixel value.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of frame.
REQ-018 SHALL have port frame_cnt, output, 16 bits: count of completed frames, wrapping 0xFFFF->0x0000.

Function
REQ-019 All outputs SHALL be registered; states SHALL be IDLE, FV_PRE, LINE, LINE_BLANK, FV_POST, FRAME_BLANK.
REQ-020 IDLE: all outputs SHALL be 0; en=1 -> FV_PRE next cycle; fval=1 SHALL appear that cycle.
REQ-021 sel SHALL be latched on IDLE->FV_PRE and FRAME_BLANK->FV_PRE only; changes mid-frame SHALL be ignored.
REQ-022 FV_PRE SHALL last exactly FV_TO_LV cycles (fval=1, lval=0), then go to LINE.
REQ-023 LINE: lval=1 every cycle; x counts 0..WIDTH-1, advancing only on dval beats; after the beat with x=WIDTH-1, go to LINE_BLANK if y<HEIGHT-1, else FV_POST.
REQ-024 hold=1 sampled in LINE SHALL make the next cycle dval=0, with x frozen, pix_data unchanged and lval kept at 1; hold outside LINE SHALL be ignored.
REQ-025 LINE_BLANK SHALL last H_BLANK cycles (fval=1, lval=0), increment y, then go to LINE.
REQ-026 FV_POST SHALL last LV_TO_FV cycles, then go to FRAME_BLANK.
REQ-027 FRAME_BLANK: fval=0 for F_BLANK cycles, then FV_PRE if en=1, else IDLE.
REQ-028 frame_done SHALL be 1 only in the first FRAME_BLANK cycle; frame_cnt SHALL increment in that same cycle.
REQ-029 en deasserted mid-frame SHALL NOT truncate the frame; the frame SHALL complete, then go to IDLE.
REQ-030 Patterns, valid when dval=1:
- sel=000: 0x00.
- sel=001: 0xFF.
- sel=010: x[7:0].
- sel=011: 0xFF if ((x>>TILE_LOG2)^(y>>TILE_LOG2)) bit0=1, else 0x00.
- sel=100: y[7:0].
- other sel values: 0x00.
REQ-031 lval SHALL never be 1 while fval=0; dval SHALL never be 1 while lval=0.
REQ-032 Counters x and y SHALL be 16 bits wide; x and y SHALL reset to 0 at each FV_PRE entry.

Reset
REQ-033 rst=0 at a clock edge SHALL force, from the next cycle: state IDLE; fval, lval, dval, pix_data, frame_done, x, y and frame_cnt all 0. This SHALL apply in any state, including mid-line.
REQ-034 After rst returns to 1, the block SHALL start its first frame only from IDLE with en=1.

Verification
Parameters for all scenarios: WIDTH=4, HEIGHT=3, FV_TO_LV=2, H_BLANK=3, LV_TO_FV=2, F_BLANK=5, TILE_LOG2=1.
REQ-035 sel=010, en=1 -> fval high 22 cycles; 3 lval pulses, each 4 cycles; each line's pix_data=00,01,02,03; lval gaps of 3 cycles.
REQ-036 sel=011 -> lines 0 and 1 = 00,00,FF,FF; line 2 = FF,FF,00,00; frame_done pulses once; frame_cnt=1.
REQ-037 hold=1 for 2 cycles after the 2nd beat of line 0 -> lval high 6 cycles; dval beats 00,01,02,03 with a 2-cycle dval gap.
REQ-038 en dropped during line 1 -> frame completes with all 12 beats; frame_done=1 once; then IDLE with fval=0 indefinitely. A sel change made during the frame SHALL take effect only in the next frame.
REQ-039 rst=0 during line 2 -> next cycle all outputs 0 and frame_cnt=0; with en=1 after release, a new full frame starts with line 0.

Source files
------------

// File: rtl/frame_timing_gen.sv
// ---------------------------------------------------------------------------
// FrameTimingGen (module frame_timing_gen)
//
// Purpose:
//   Generates camera-style frame timing (fval / lval / dval) with a selectable
//   test pattern on pix_data. Each frame has the following phases:
//     FV_PRE      fval=1, lval=0 for FV_TO_LV cycles
//     LINE        lval=1, one dval beat per pixel (stalls on hold)
//     LINE_BLANK  fval=1, lval=0 for H_BLANK cycles between lines
//     FV_POST     fval=1, lval=0 for LV_TO_FV cycles after the last line
//     FRAME_BLANK fval=0 for F_BLANK cycles; frame_done pulses on entry
//   All timing parameters are expected to be at least 1.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active low
//   en         in   frame generation enable (sampled at frame boundaries)
//   sel[2:0]   in   pattern select, latched when a frame starts
//   hold       in   pixel stall request, honoured only inside a line
//   fval       out  frame valid
//   lval       out  line valid
//   dval       out  data valid (one pixel beat)
//   pix_data   out  pixel value, meaningful while dval=1
//   frame_done out  one-cycle pulse in the first FRAME_BLANK cycle
//   frame_cnt  out  completed-frame count, wraps at 16 bits
// ---------------------------------------------------------------------------
module frame_timing_gen #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int FV_TO_LV  = 4,
    parameter int H_BLANK   = 16,
    parameter int LV_TO_FV  = 4,
    parameter int F_BLANK   = 32,
    parameter int TILE_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  sel,
    input  logic        hold,
    output logic        fval,
    output logic        lval,
    output logic        dval,
    output logic [7:0]  pix_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        FV_PRE,
        LINE,
        LINE_BLANK,
        FV_POST,
        FRAME_BLANK
    } state_e;

    localparam logic [15:0] X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST    = 16'(HEIGHT - 1);
    localparam logic [15:0] PRE_LAST  = 16'(FV_TO_LV - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] POST_LAST = 16'(LV_TO_FV - 1);
    localparam logic [15:0] FB_LAST   = 16'(F_BLANK - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [2:0]  sel_q, sel_d;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic        dval_q, dval_d;
    logic [7:0]  pix_q, pix_d;
    logic        done_q, done_d;
    logic [15:0] fcnt_q, fcnt_d;

    // Pattern value for pixel (px, py) under pattern select s. The checker
    // takes bit 0 of the tile coordinates so tiles alternate in both axes.
    function automatic logic [7:0] pattern_pix(input logic [2:0]  s,
                                               input logic [15:0] px,
                                               input logic [15:0] py);
        logic [15:0] tx;
        logic [15:0] ty;
        tx = px >> TILE_LOG2;
        ty = py >> TILE_LOG2;
        case (s)
            3'b000:  pattern_pix = 8'h00;
            3'b001:  pattern_pix = 8'hFF;
            3'b010:  pattern_pix = px[7:0];
            3'b011:  pattern_pix = (tx[0] ^ ty[0]) ? 8'hFF : 8'h00;
            3'b100:  pattern_pix = py[7:0];
            default: pattern_pix = 8'h00;
        endcase
    endfunction

    // Next-state and next-output logic. Outputs are computed for the cycle
    // being entered and then registered, so every output is a flop. x_q holds
    // the x of the most recently presented pixel; a line therefore ends once
    // the pixel at WIDTH-1 is on the outputs, regardless of hold. cnt_q counts
    // cycles spent in the current timed phase and restarts at 0 on each entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        fval_d  = 1'b0;
        lval_d  = 1'b0;
        dval_d  = 1'b0;
        pix_d   = 8'h00;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FV_PRE;
                    cnt_d   = 16'd0;
                    x_d     = 16'd0;
                    y_d     = 16'd0;
                    sel_d   = sel;
                    fval_d  = 1'b1;
                end
            end

            FV_PRE: begin
                fval_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = LINE;
                    cnt_d   = 16'd0;
                    x_d     = 16'd0;
                    lval_d  = 1'b1;
                    dval_d  = 1'b1;
                    pix_d   = pattern_pix(sel_q, 16'd0, y_q);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            LINE: begin
                fval_d = 1'b1;
                if (x_q == X_LAST) begin
                    // Last pixel of the line is on the outputs now.
                    cnt_d   = 16'd0;
                    state_d = (y_q < Y_LAST) ? LINE_BLANK : FV_POST;
                end else if (hold) begin
                    // Stall: keep the line open and repeat the last value.
                    lval_d = 1'b1;
                    pix_d  = pix_q;
                end else begin
                    lval_d = 1'b1;
                    dval_d = 1'b1;
                    x_d    = x_q + 16'd1;
                    pix_d  = pattern_pix(sel_q, x_q + 16'd1, y_q);
                end
            end

            LINE_BLANK: begin
                fval_d = 1'b1;
                if (cnt_q == HB_LAST) begin
                    state_d = LINE;
                    cnt_d   = 16'd0;
                    x_d     = 16'd0;
                    y_d     = y_q + 16'd1;
                    lval_d  = 1'b1;
                    dval_d  = 1'b1;
                    pix_d   = pattern_pix(sel_q, 16'd0, y_q + 16'd1);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            FV_POST: begin
                fval_d = 1'b1;
                if (cnt_q == POST_LAST) begin
                    state_d = FRAME_BLANK;
                    cnt_d   = 16'd0;
                    fval_d  = 1'b0;
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            FRAME_BLANK: begin
                // en is only looked at here and in IDLE, so dropping it
                // mid-frame lets the current frame run to completion.
                if (cnt_q == FB_LAST) begin
                    if (en) begin
                        state_d = FV_PRE;
                        cnt_d   = 16'd0;
                        x_d     = 16'd0;
                        y_d     = 16'd0;
                        sel_d   = sel;
                        fval_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 16'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            sel_q   <= 3'd0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            dval_q  <= 1'b0;
            pix_q   <= 8'h00;
            done_q  <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            dval_q  <= dval_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign fval       = fval_q;
    assign lval       = lval_q;
    assign dval       = dval_q;
    assign pix_data   = pix_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_frame_timing_gen
//
// Self-checking bench for frame_timing_gen with small timing parameters.
// A reference model expands each frame into a queue of expected output
// cycles built directly from the frame layout (pre, lines, gaps, post,
// blank), and stalls are modelled by inserting gap cycles into that queue.
// ---------------------------------------------------------------------------
module tb_frame_timing_gen;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int PRE  = 2;
    localparam int HB   = 3;
    localparam int POST = 2;
    localparam int FB   = 5;
    localparam int TL   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  sel;
    logic        hold;
    logic        fval;
    logic        lval;
    logic        dval;
    logic [7:0]  pix_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic       fval;
        logic       lval;
        logic       dval;
        logic [7:0] pix;
        logic       done;
        logic       pixChk;
    } expCycle_t;

    expCycle_t   expQ[$];
    expCycle_t   expCur;
    logic [15:0] expCnt;

    int checks   = 0;
    int failures = 0;

    int fvalCycles;
    int lvalCycles;
    int beatCount;
    int donePulses;

    int holdLeft;
    bit holdArmed;

    frame_timing_gen #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .FV_TO_LV (PRE),
        .H_BLANK  (HB),
        .LV_TO_FV (POST),
        .F_BLANK  (FB),
        .TILE_LOG2(TL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sel       (sel),
        .hold      (hold),
        .fval      (fval),
        .lval      (lval),
        .dval      (dval),
        .pix_data  (pix_data),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic expCycle_t mkCycle(input logic f, input logic l, input logic d,
                                          input logic [7:0] p, input logic dn,
                                          input logic pc);
        expCycle_t c;
        c.fval   = f;
        c.lval   = l;
        c.dval   = d;
        c.pix    = p;
        c.done   = dn;
        c.pixChk = pc;
        return c;
    endfunction

    // Pattern value computed from the pixel coordinates with plain integers.
    function automatic logic [7:0] refPixel(input logic [2:0] s, input int x, input int y);
        case (s)
            3'd0:    return 8'h00;
            3'd1:    return 8'hFF;
            3'd2:    return 8'(x % 256);
            3'd3:    return ((((x >> TL) + (y >> TL)) % 2) == 1) ? 8'hFF : 8'h00;
            3'd4:    return 8'(y % 256);
            default: return 8'h00;
        endcase
    endfunction

    // Expand one whole frame into the expected-cycle queue.
    task automatic buildFrame(input logic [2:0] s);
        for (int i = 0; i < PRE; i++) expQ.push_back(mkCycle(1, 0, 0, 8'h00, 0, 0));
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++)
                expQ.push_back(mkCycle(1, 1, 1, refPixel(s, x, y), 0, 1));
            if (y < H - 1)
                for (int i = 0; i < HB; i++) expQ.push_back(mkCycle(1, 0, 0, 8'h00, 0, 0));
        end
        for (int i = 0; i < POST; i++) expQ.push_back(mkCycle(1, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < FB; i++) expQ.push_back(mkCycle(0, 0, 0, 8'h00, i == 0, 0));
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic modelStep();
        if (!rst) begin
            expQ.delete();
            expCur = mkCycle(0, 0, 0, 8'h00, 0, 1);
            expCnt = 16'd0;
            return;
        end
        // A stall inside a line that still has pixels to send adds a gap.
        if (expCur.lval && hold && expQ.size() > 0 && expQ[0].lval)
            expQ.push_front(mkCycle(1, 1, 0, expCur.pix, 0, 1));
        if (expQ.size() == 0 && en)
            buildFrame(sel);
        if (expQ.size() == 0)
            expCur = mkCycle(0, 0, 0, 8'h00, 0, 1);
        else
            expCur = expQ.pop_front();
        if (expCur.done)
            expCnt = expCnt + 16'd1;
    endtask

    // Compare every output with the model and keep per-scenario tallies.
    task automatic compareOutputs();
        checkOutput("fval", 16'(fval), 16'(expCur.fval));
        checkOutput("lval", 16'(lval), 16'(expCur.lval));
        checkOutput("dval", 16'(dval), 16'(expCur.dval));
        if (expCur.pixChk)
            checkOutput("pix_data", 16'(pix_data), 16'(expCur.pix));
        checkOutput("frame_done", 16'(frame_done), 16'(expCur.done));
        checkOutput("frame_cnt", frame_cnt, expCnt);
        fvalCycles += int'(fval);
        lvalCycles += int'(lval);
        beatCount  += int'(dval);
        donePulses += int'(frame_done);
    endtask

    // Drive one cycle of inputs, step the model, then check after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] s,
                                 input logic h);
        rst  = r;
        en   = e;
        sel  = s;
        hold = h;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        compareOutputs();
    endtask

    task automatic clearTallies();
        fvalCycles = 0;
        lvalCycles = 0;
        beatCount  = 0;
        donePulses = 0;
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        rst    = 1'b0;
        en     = 1'b0;
        sel    = 3'd0;
        hold   = 1'b0;
        expCur = mkCycle(0, 0, 0, 8'h00, 0, 1);
        expCnt = 16'd0;
        clearTallies();

        // Reset with en low: everything zero.
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 3'd0, 0);
        for (int c = 0; c < 3; c++) applyStimulus(1, 0, 3'd0, 0);

        // One frame of the x ramp.
        clearTallies();
        for (int c = 0; c < 40; c++) applyStimulus(1, c == 0, 3'd2, 0);
        checkOutput("ramp_fval_cycles", 16'(fvalCycles), 16'd22);
        checkOutput("ramp_lval_cycles", 16'(lvalCycles), 16'd12);
        checkOutput("ramp_done_pulses", 16'(donePulses), 16'd1);
        checkOutput("ramp_frame_cnt", frame_cnt, 16'd1);

        // One frame of the checkerboard.
        clearTallies();
        for (int c = 0; c < 40; c++) applyStimulus(1, c == 0, 3'd3, 0);
        checkOutput("checker_done_pulses", 16'(donePulses), 16'd1);
        checkOutput("checker_frame_cnt", frame_cnt, 16'd2);

        // Two-cycle stall right after the second pixel of line 0.
        clearTallies();
        holdLeft  = 0;
        holdArmed = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (holdArmed && expCur.dval && expCur.lval && expCur.pix == 8'h01) begin
                holdLeft  = 2;
                holdArmed = 1'b0;
            end
            applyStimulus(1, c == 0, 3'd2, holdLeft > 0);
            if (holdLeft > 0) holdLeft--;
        end
        checkOutput("hold_lval_cycles", 16'(lvalCycles), 16'd14);
        checkOutput("hold_beats", 16'(beatCount), 16'd12);

        // en dropped and sel changed during line 1; frame still completes.
        clearTallies();
        for (int c = 0; c < 60; c++)
            applyStimulus(1, c < 11, (c < 11) ? 3'd3 : 3'd4, 0);
        checkOutput("endrop_beats", 16'(beatCount), 16'd12);
        checkOutput("endrop_done_pulses", 16'(donePulses), 16'd1);
        checkOutput("endrop_idle_fval", 16'(fval), 16'd0);
        clearTallies();
        for (int c = 0; c < 40; c++) applyStimulus(1, c == 0, 3'd4, 0);
        checkOutput("next_frame_beats", 16'(beatCount), 16'd12);

        // Reset during line 2, then a fresh frame.
        for (int c = 0; c < 18; c++) applyStimulus(1, 1, 3'd2, 0);
        applyStimulus(0, 1, 3'd2, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 16'd0);
        checkOutput("rst_fval", 16'(fval), 16'd0);
        clearTallies();
        for (int c = 0; c < 40; c++) applyStimulus(1, c == 0, 3'd2, 0);
        checkOutput("post_rst_beats", 16'(beatCount), 16'd12);
        checkOutput("post_rst_frame_cnt", frame_cnt, 16'd1);

        // Randomized enables, selects, stalls and occasional resets.
        for (int c = 0; c < 3000; c++)
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                          3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
